// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the 8 KB data memory: one request at a time, one access cycle.
// Optional LSU_MISALIGN_TRAP_EN: misaligned/illegal requests return resp_err instead of being force-aligned.
module lsu_ctrl #(
  parameter int          DM_AW       = 11,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_len,
  input  logic             req_sext,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [DM_AW-1:0] dm_addr,
  output logic [3:0]       dm_be,
  output logic [31:0]      dm_din,
  output logic             dm_we,
  input  logic [31:0]      dm_dout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]       state;
  logic [DM_AW+1:0] addr_q;
  logic [1:0]       len_q;
  logic             we_q;
  logic             sext_q;
  logic [31:0]      wdata_q;

  logic [1:0]       len_eff;
  logic [DM_AW+1:0] addr_eff;
  logic             err_next;
  logic [3:0]       be;
  logic [31:0]      shifted;
  logic [31:0]      load_val;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:DM_AW+2];

  always_comb begin
    len_eff  = req_len;
    addr_eff = req_addr[DM_AW+1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    err_next = (req_len == 2'b11) ||
               (req_len == 2'b01 && req_addr[0]) ||
               (req_len == 2'b10 && req_addr[1:0] != 2'b00);
`else
    // Without trapping, illegal length becomes a word and low address bits are dropped.
    err_next = 1'b0;
    if (req_len == 2'b11) len_eff = 2'b10;
    if (len_eff == 2'b01) addr_eff[0] = 1'b0;
    if (len_eff == 2'b10) addr_eff[1:0] = 2'b00;
`endif
  end

  always_comb begin
    case (len_q)
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory returns data in its byte lane; bring the addressed bytes down to bit 0.
  always_comb begin
    shifted = dm_dout >> {addr_q[1:0], 3'b000};
    case (len_q)
      2'b00:   load_val = sext_q ? {{24{shifted[7]}}, shifted[7:0]}
                                 : {24'h000000, shifted[7:0]};
      2'b01:   load_val = sext_q ? {{16{shifted[15]}}, shifted[15:0]}
                                 : {16'h0000, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Memory port is gated by the state so reset removes dm_we without waiting for a clock.
  assign dm_addr    = (state == ACCESS) ? addr_q[DM_AW+1:2] : '0;
  assign dm_be      = (state == ACCESS) ? be : 4'b0000;
  assign dm_din     = (state == ACCESS) ? wdata_q : 32'h0;
  assign dm_we      = (state == ACCESS) && we_q;
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      len_q      <= 2'b00;
      we_q       <= 1'b0;
      sext_q     <= 1'b0;
      wdata_q    <= 32'h0;
      resp_rdata <= RESET_RDATA;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= addr_eff;
            len_q   <= len_eff;
            we_q    <= req_we;
            sext_q  <= req_sext;
            wdata_q <= req_wdata;
            if (err_next) begin
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
              state      <= RESP;
            end else begin
              resp_err <= 1'b0;
              state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          resp_rdata <= we_q ? 32'h0 : load_val;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: byte-array reference memory model, per-cycle compare, directed vectors.
module tb_lsu_ctrl;

  localparam int DM_AW = 11;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_we, req_sext;
  logic [1:0]       req_len;
  logic [31:0]      req_addr, req_wdata;
  logic             resp_valid, resp_ready, resp_err;
  logic [31:0]      resp_rdata;
  logic [DM_AW-1:0] dm_addr;
  logic [3:0]       dm_be;
  logic [31:0]      dm_din, dm_dout;
  logic             dm_we;

  always #5 clk = ~clk;

  lsu_ctrl #(.DM_AW(DM_AW), .RESET_RDATA(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_len(req_len), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dm_addr(dm_addr), .dm_be(dm_be), .dm_din(dm_din),
    .dm_we(dm_we), .dm_dout(dm_dout)
  );

  // Stand-in for dm_8k: negedge write, low din bytes routed to the enabled lanes in order.
  logic [31:0] dmem [0:2047];
  int wr_j;
  always @(negedge clk) begin
    if (dm_we) begin
      wr_j = 0;
      for (int k = 0; k < 4; k++) begin
        if (dm_be[k]) begin
          dmem[dm_addr][8*k +: 8] <= dm_din[8*wr_j +: 8];
          wr_j++;
        end
      end
    end
  end
  assign dm_dout = dmem[dm_addr] & {{8{dm_be[3]}}, {8{dm_be[2]}}, {8{dm_be[1]}}, {8{dm_be[0]}}};

  // Reference model: flat byte array addressed by the 13-bit byte address.
  logic [7:0] mdl [0:8191];

  int checks = 0;
  int failures = 0;
  bit busy = 1'b0;
  bit cur_err = 1'b0;
  bit watch_stable = 1'b0;
  logic [31:0] held_rdata;
  logic held_err;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic int mdl_bytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit mdl_err(input logic [1:0] len, input logic [31:0] a);
    if (!TRAP) return 1'b0;
    return (len == 2'd3) || (len == 2'd1 && a % 2 != 0) || (len == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] mdl_base(input logic [1:0] len, input logic [31:0] a);
    int n;
    n = mdl_bytes(len);
    return TRAP ? a : a - (a % n);
  endfunction

  task automatic mdl_store(input logic [1:0] len, input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic [31:0] base;
    n = mdl_bytes(len);
    base = mdl_base(len, a);
    for (int i = 0; i < n; i++) mdl[(base + i) % 8192] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] mdl_load(input logic [1:0] len, input bit sext, input logic [31:0] a);
    int n;
    logic [31:0] base, v;
    n = mdl_bytes(len);
    base = mdl_base(len, a);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mdl[(base + i) % 8192]) << (8*i));
    if (sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic logic [3:0] mdl_be(input logic [1:0] len, input logic [31:0] a);
    int n;
    logic [31:0] base;
    n = mdl_bytes(len);
    base = mdl_base(len, a);
    if (n == 1) return 4'(1 << (base % 4));
    if (n == 2) return (base % 4 == 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  // Per-cycle compare against the model's notion of busy/error and held response.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("req_ready", {31'h0, req_ready}, {31'h0, !busy});
      if (watch_stable) begin
        checkOutput("hold_valid", {31'h0, resp_valid}, 32'h1);
        checkOutput("hold_rdata", resp_rdata, held_rdata);
        checkOutput("hold_err", {31'h0, resp_err}, {31'h0, held_err});
      end
      if (busy && cur_err) begin
        checkOutput("err_no_we", {31'h0, dm_we}, 32'h0);
        checkOutput("err_no_be", {28'h0, dm_be}, 32'h0);
      end
    end
  end

  // One full transaction; entered just after a posedge with the DUT idle.
  task automatic applyStimulus(input bit we, input logic [1:0] len, input bit sext,
                               input logic [31:0] a, input logic [31:0] wd, input int hold,
                               output logic [31:0] rdata, output logic [3:0] be_seen);
    bit acc, exp_err, we_seen;
    int tries, lat;
    logic [31:0] exp_rd;
    exp_err = mdl_err(len, a);
    exp_rd  = (we || exp_err) ? 32'h0 : mdl_load(len, sext, a);
    req_we = we; req_len = len; req_sext = sext; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    acc = 1'b0; tries = 0;
    rdata = 32'h0; be_seen = 4'h0; we_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin acc = 1'b1; tries = i; break; end
    end
    if (!acc) begin
      checkOutput("accept_timeout", 32'h0, 32'h1);
      req_valid = 1'b0;
      return;
    end
    checkOutput("accept_wait", tries, 32'h0);
    @(posedge clk); #1;
    busy = 1'b1; cur_err = exp_err;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_len = 2'($urandom); req_sext = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (we && !exp_err) mdl_store(len, a, wd);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin be_seen = dm_be; we_seen = dm_we; end
      if (resp_valid) begin lat = i; break; end
    end
    checkOutput("latency", lat, exp_err ? 32'd1 : 32'd2);
    checkOutput("resp_rdata", resp_rdata, exp_rd);
    checkOutput("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
    if (!exp_err) begin
      checkOutput("access_be", {28'h0, be_seen}, {28'h0, mdl_be(len, a)});
      checkOutput("access_we", {31'h0, we_seen}, {31'h0, we});
    end
    rdata = resp_rdata;
    held_rdata = resp_rdata; held_err = resp_err; watch_stable = 1'b1;
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    watch_stable = 1'b0; busy = 1'b0; cur_err = 1'b0;
  endtask

  logic [31:0] rd;
  logic [3:0]  be;

  initial begin
    for (int i = 0; i < 2048; i++) dmem[i] = 32'h0;
    for (int i = 0; i < 8192; i++) mdl[i] = 8'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_len = 2'b00; req_sext = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    #2;
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("rst_resp_err", {31'h0, resp_err}, 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_dm_we", {31'h0, dm_we}, 32'h0);
    checkOutput("rst_dm_be", {28'h0, dm_be}, 32'h0);
    checkOutput("rst_dm_addr", {21'h0, dm_addr}, 32'h0);
    checkOutput("rst_dm_din", dm_din, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] byte store then word load");
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_0006, 32'h0000_00A5, 0, rd, be);
    checkOutput("pin_be_byte6", {28'h0, be}, 32'h4);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0, 0, rd, be);
    checkOutput("pin_word4", rd, 32'h00A5_0000);

    $display("[TB] halfword store, signed/unsigned loads with held response");
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_8001, 0, rd, be);
    checkOutput("pin_be_half12", {28'h0, be}, 32'hC);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, 5, rd, be);
    checkOutput("pin_half_sext", rd, 32'hFFFF_8001);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 0, rd, be);
    checkOutput("pin_half_zext", rd, 32'h0000_8001);

    $display("[TB] word store, signed byte load");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'h80FF_0000, 0, rd, be);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_0007, 32'h0, 0, rd, be);
    checkOutput("pin_byte7_sext", rd, 32'hFFFF_FF80);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0, 2, rd, be);
    checkOutput("pin_byte6_zext", rd, 32'h0000_00FF);

    $display("[TB] misaligned and illegal-length requests");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0002, 32'hDEAD_BEEF, 0, rd, be);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 0, rd, be);
    checkOutput("pin_word0_after_misaligned", rd, TRAP ? 32'h0000_0000 : 32'hDEAD_BEEF);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h0000_0004, 32'h0, 0, rd, be);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_0013, 32'h0, 1, rd, be);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_1FFD, 32'h1234_567C, 0, rd, be);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_1FFC, 32'h0, 0, rd, be);
    checkOutput("pin_top_word", rd, 32'h0000_7C00);

    $display("[TB] reset during store access");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1122_3344, 0, rd, be);
    req_we = 1'b1; req_len = 2'b10; req_sext = 1'b0; req_addr = 32'h0000_0100;
    req_wdata = 32'hAAAA_AAAA; req_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_test_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    #1;
    checkOutput("midrst_dm_we", {31'h0, dm_we}, 32'h0);
    checkOutput("midrst_dm_be", {28'h0, dm_be}, 32'h0);
    checkOutput("midrst_dm_addr", {21'h0, dm_addr}, 32'h0);
    checkOutput("midrst_dm_din", dm_din, 32'h0);
    checkOutput("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("midrst_resp_rdata", resp_rdata, 32'h0);
    @(negedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 0, rd, be);
    checkOutput("pin_word100_after_rst", rd, 32'h1122_3344);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage sitting directly upstream of the 8 KB data memory (dm_8k).
- Accepts one memory request at a time from the MEM pipeline stage over a valid/ready handshake.
- Drives the data-memory port (word address, byte enables, low-justified store data, write enable) for exactly one access cycle.
- Returns aligned, sign- or zero-extended load data over a valid/ready response handshake.

Parameters:
- DM_AW, 11: data-memory word-address width; dm_addr carries addr[DM_AW+1:2].
- RESET_RDATA, 32'h00000000: value of resp_rdata after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_len  in  2  00 byte, 01 halfword, 10 word; 11 is illegal.
- req_sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low-justified.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned or illegal-length request; no memory write occurred.
- dm_addr  out  DM_AW  word address to the data memory.
- dm_be  out  4  byte enables.
- dm_din  out  32  store data to the data memory.
- dm_we  out  1  write enable to the data memory.
- dm_dout  in  32  read data from the data memory, lane-positioned, masked by dm_be.

Behaviour:
- Reset state (async, rst=1):
  - state=IDLE.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=RESET_RDATA.
  - dm_we=0, dm_be=0, dm_addr=0, dm_din=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch addr, len, we, sext, wdata. Go to ACCESS, or to RESP with err=1 if misaligned.
  - Misaligned means: len=01 with addr[0]=1; len=10 with addr[1:0]!=0; or len=11.
- ACCESS (exactly one cycle):
  - dm_addr = latched addr[DM_AW+1:2].
  - dm_be:
    - byte: one-hot at lane addr[1:0].
    - half: 0011 if addr[1]=0, else 1100.
    - word: 1111.
  - dm_din = latched wdata, unshifted (the memory routes low bytes to the enabled lanes).
  - dm_we = latched we. It is high for the whole cycle so the memory's negedge write lands mid-cycle.
  - At the closing posedge, for loads:
    - shift dm_dout right by 8*addr[1:0];
    - keep 8 or 16 bits, or the full 32 for a word;
    - extend per sext;
    - register into resp_rdata.
  - For stores, resp_rdata=0. Then go to RESP.
- RESP:
  - resp_valid=1.
  - dm_we=0, dm_be=0.
  - resp_rdata and resp_err are held stable until resp_valid&resp_ready, then go to IDLE.
  - Because req_ready is only asserted in IDLE, a response accepted in cycle N allows a new request to be accepted in cycle N+1.
- Latency: request accepted at edge T → resp_valid at edge T+2 (valid) or T+1 (error).
- Error responses never assert dm_we or a nonzero dm_be.
- Reset mid-ACCESS: dm_we drops asynchronously. A store whose negedge has not yet occurred is dropped; no partial write occurs after rst rises.
- Inputs are ignored outside IDLE. req_* may change freely once accepted.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests and len=11 produce resp_err=1 with no memory access, as described above.
- Undefined:
  - resp_err is tied to 0.
  - len=11 is treated as a word access.
  - Misaligned addresses are force-aligned (halfword clears addr[0]; word clears addr[1:0]) and the access proceeds normally through ACCESS.

Test Plan:
- Store byte 0xA5 at 0x0000_0006, then load word at 0x4 → dm_be=0100 during ACCESS; word read returns 0x00A5_0000.
- Store half 0x8001 at 0x0000_0012, then load half with sext=1 at 0x12 → resp_rdata=0xFFFF_8001; with sext=0 → 0x0000_8001.
- Load byte with sext=1 at 0x7 after word store 0x80FF_0000 at 0x4 → resp_rdata=0xFFFF_FF80.
- With LSU_MISALIGN_TRAP_EN defined, store word at 0x0000_0002 → resp_err=1 one cycle after accept, dm_we never high, memory unchanged. Undefined → write lands at word 0x0.
- Hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata stable, req_ready=0; new request accepted the cycle after the handshake.
- Assert rst during ACCESS of a store before the negedge → outputs return to reset values immediately, target word unchanged on readback.
